// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates sprite rectangle-draw requests and a full-screen clear
// onto a single drawer/eraser datapath. Clear has strict priority; draw requests are
// served round-robin. Each job holds drw_en high until drw_done (or watchdog abort),
// then drops drw_en for one RELEASE cycle so the drawer re-arms, and acks the source.
module draw_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_req,
    output logic                 clear_ack,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [5*NUM_REQ-1:0] req_w,
    input  logic [5*NUM_REQ-1:0] req_h,
    input  logic [3*NUM_REQ-1:0] req_c,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           drw_x,
    output logic [6:0]           drw_y,
    output logic [4:0]           drw_w,
    output logic [4:0]           drw_h,
    output logic [2:0]           drw_c,
    output logic                 drw_en,
    output logic                 erase_mode,
    input  logic                 drw_done,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WdW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StDraw,
        StSkip,
        StRelease
    } state_e;

    state_e              state_q;
    logic [IdxW-1:0]     rr_ptr_q;
    logic [IdxW-1:0]     grant_q;
    logic                is_clear_q;
    logic [WdW-1:0]      wdog_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic                clear_ack_q;
    logic [7:0]          drw_x_q;
    logic [6:0]          drw_y_q;
    logic [4:0]          drw_w_q;
    logic [4:0]          drw_h_q;
    logic [2:0]          drw_c_q;
    logic                drw_en_q;
    logic                erase_mode_q;
    logic                busy_q;
    logic                timeout_err_q;

    logic                gnt_found;
    logic [IdxW-1:0]     gnt_idx;
    logic [7:0]          sel_x;
    logic [6:0]          sel_y;
    logic [4:0]          sel_w;
    logic [4:0]          sel_h;
    logic [2:0]          sel_c;
    logic                job_ok;
    logic [IdxW-1:0]     rr_next;

    // Round-robin search: first asserted request starting at rr_ptr, wrapping mod NUM_REQ.
    always_comb begin
        logic [IdxW:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NUM_REQ)) begin
                cand = cand - (IdxW+1)'(NUM_REQ);
            end
            if (!gnt_found && req[cand[IdxW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IdxW-1:0];
            end
        end
    end

    assign sel_x = req_x[8*gnt_idx +: 8];
    assign sel_y = req_y[7*gnt_idx +: 7];
    assign sel_w = req_w[5*gnt_idx +: 5];
    assign sel_h = req_h[5*gnt_idx +: 5];
    assign sel_c = req_c[3*gnt_idx +: 3];

    // Zero-size or off-screen origins are acked without touching the drawer.
    assign job_ok = (sel_w != 5'd0) && (sel_h != 5'd0) &&
                    (sel_x <= 8'd159) && (sel_y <= 7'd119);

    assign rr_next = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            is_clear_q    <= 1'b0;
            wdog_q        <= '0;
            ack_q         <= '0;
            clear_ack_q   <= 1'b0;
            drw_x_q       <= '0;
            drw_y_q       <= '0;
            drw_w_q       <= '0;
            drw_h_q       <= '0;
            drw_c_q       <= '0;
            drw_en_q      <= 1'b0;
            erase_mode_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            ack_q       <= '0;
            clear_ack_q <= 1'b0;
            // A watchdog set later in this block overrides the clear.
            if (err_clr) begin
                timeout_err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    wdog_q <= '0;
                    if (clear_req) begin
                        state_q      <= StClear;
                        is_clear_q   <= 1'b1;
                        erase_mode_q <= 1'b1;
                        drw_en_q     <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (gnt_found) begin
                        grant_q    <= gnt_idx;
                        is_clear_q <= 1'b0;
                        drw_x_q    <= sel_x;
                        drw_y_q    <= sel_y;
                        drw_w_q    <= sel_w;
                        drw_h_q    <= sel_h;
                        drw_c_q    <= sel_c;
                        busy_q     <= 1'b1;
                        if (job_ok) begin
                            state_q  <= StDraw;
                            drw_en_q <= 1'b1;
                        end else begin
                            state_q        <= StSkip;
                            ack_q[gnt_idx] <= 1'b1;
                        end
                    end
                end

                StClear, StDraw: begin
                    if (drw_done || (wdog_q == WdW'(TIMEOUT_CYC - 1))) begin
                        if (!drw_done) begin
                            timeout_err_q <= 1'b1;
                        end
                        state_q      <= StRelease;
                        drw_en_q     <= 1'b0;
                        erase_mode_q <= 1'b0;
                        if (is_clear_q) begin
                            clear_ack_q <= 1'b1;
                        end else begin
                            ack_q[grant_q] <= 1'b1;
                        end
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end

                StRelease: begin
                    if (!is_clear_q) begin
                        rr_ptr_q <= rr_next;
                    end
                    wdog_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                StSkip: begin
                    rr_ptr_q <= rr_next;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign clear_ack   = clear_ack_q;
    assign ack         = ack_q;
    assign drw_x       = drw_x_q;
    assign drw_y       = drw_y_q;
    assign drw_w       = drw_w_q;
    assign drw_h       = drw_h_q;
    assign drw_c       = drw_c_q;
    assign drw_en      = drw_en_q;
    assign erase_mode  = erase_mode_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: batches of requests are issued while idle, the
// expected service order is computed from the priority/round-robin rules and queued,
// and a monitor checks each drawer start and each ack against the queue.
module tb_draw_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           clear_req = 1'b0;
    logic           drw_done = 1'b0;
    logic           err_clr = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_x = '0;
    logic [7*N-1:0] req_y = '0;
    logic [5*N-1:0] req_w = '0;
    logic [5*N-1:0] req_h = '0;
    logic [3*N-1:0] req_c = '0;
    logic           clear_ack;
    logic [N-1:0]   ack;
    logic [7:0]     drw_x;
    logic [6:0]     drw_y;
    logic [4:0]     drw_w;
    logic [4:0]     drw_h;
    logic [2:0]     drw_c;
    logic           drw_en;
    logic           erase_mode;
    logic           busy;
    logic           timeout_err;

    draw_scheduler #(
        .NUM_REQ    (N),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_ack  (clear_ack),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_c      (req_c),
        .ack        (ack),
        .drw_x      (drw_x),
        .drw_y      (drw_y),
        .drw_w      (drw_w),
        .drw_h      (drw_h),
        .drw_c      (drw_c),
        .drw_en     (drw_en),
        .erase_mode (erase_mode),
        .drw_done   (drw_done),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         clr;
        bit         skip;
        int         idx;
        logic [7:0] x;
        logic [6:0] y;
        logic [4:0] w;
        logic [4:0] h;
        logic [2:0] c;
    } job_t;

    job_t       exp_q[$];
    int         vectors = 0;
    int         errors = 0;
    int         rr_m = 0;
    bit         hold_done = 1'b0;
    logic [7:0] fx[N];
    logic [6:0] fy[N];
    logic [4:0] fw[N];
    logic [4:0] fh[N];
    logic [2:0] fc[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drawer model: finishes 0..4 cycles after drw_en rises unless held off.
    always @(negedge clk) begin
        int lat;
        if (drw_en && !drw_done && !hold_done) begin
            if (lat == 0) drw_done = 1'b1;
            else lat--;
        end else begin
            drw_done = 1'b0;
            lat = $urandom_range(0, 4);
        end
    end

    // Service order: clear first, then round-robin over the requested set.
    task automatic issue(input logic [N-1:0] mask, input bit clr);
        logic [N-1:0] pend;
        job_t j;
        if (clr) begin
            j = '{clr: 1'b1, skip: 1'b0, idx: 0, x: '0, y: '0, w: '0, h: '0, c: '0};
            exp_q.push_back(j);
        end
        pend = mask;
        while (pend != 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (rr_m + k) % N;
                if (pend[i]) begin
                    j.clr  = 1'b0;
                    j.idx  = i;
                    j.x    = fx[i];
                    j.y    = fy[i];
                    j.w    = fw[i];
                    j.h    = fh[i];
                    j.c    = fc[i];
                    j.skip = (fw[i] == 0) || (fh[i] == 0) || (fx[i] > 159) || (fy[i] > 119);
                    exp_q.push_back(j);
                    rr_m = (i + 1) % N;
                    pend[i] = 1'b0;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            req_x[8*i +: 8] = fx[i];
            req_y[7*i +: 7] = fy[i];
            req_w[5*i +: 5] = fw[i];
            req_h[5*i +: 5] = fh[i];
            req_c[3*i +: 3] = fc[i];
        end
        req       = mask;
        clear_req = clr;
    endtask

    // Requesters hold each request until its ack, then drop it.
    task automatic wait_done(output int en_cycles);
        int budget;
        en_cycles = 0;
        budget = 0;
        while ((req != 0 || clear_req) && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (drw_en) en_cycles++;
            req = req & ~ack;
            if (clear_ack) clear_req = 1'b0;
        end
        if (budget >= 2000) begin
            vectors++;
            errors++;
            $display("FAIL drain: requests still pending %b clr %b after %0d cycles",
                     req, clear_req, budget);
            req = '0;
            clear_req = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            fx[i] = 8'($urandom_range(0, 175));
            fy[i] = 7'($urandom_range(0, 127));
            fw[i] = 5'($urandom_range(0, 31));
            fh[i] = 5'($urandom_range(0, 31));
            fc[i] = 3'($urandom_range(0, 7));
        end
    endtask

    // Monitor: check each drawer start against the queue head, pop on each ack.
    bit   prev_en = 1'b0;
    bit   started = 1'b0;
    job_t mj;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_en = 1'b0;
            started = 1'b0;
        end else begin
            if (drw_en && !prev_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_en", 64'(drw_en), 64'(0));
                end else begin
                    mj = exp_q[0];
                    check("erase_mode", 64'(erase_mode), 64'(mj.clr));
                    if (!mj.clr) begin
                        check("drw_fields", 64'({drw_x, drw_y, drw_w, drw_h, drw_c}),
                              64'({mj.x, mj.y, mj.w, mj.h, mj.c}));
                    end
                    started = 1'b1;
                end
            end
            if (ack != 0 || clear_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'({clear_ack, ack}), 64'(0));
                end else begin
                    logic [N-1:0] exp_ack;
                    mj = exp_q.pop_front();
                    exp_ack = mj.clr ? '0 : N'(1 << mj.idx);
                    check("ack", 64'({clear_ack, ack}), 64'({mj.clr, exp_ack}));
                    check("en_low_at_ack", 64'(drw_en), 64'(0));
                    check("job_drawn", 64'(started), 64'(!mj.skip));
                    started = 1'b0;
                end
            end
            prev_en = drw_en;
        end
    end

    initial begin
        int en_cyc;
        repeat (3) @(negedge clk);
        check("rst_drw_en", 64'(drw_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ack", 64'({clear_ack, ack}), 64'(0));
        check("rst_err", 64'({timeout_err, erase_mode}), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single draw from source 1: drw_en the cycle after the request is seen.
        for (int i = 0; i < N; i++) begin
            fx[i] = 8'd1; fy[i] = 7'd1; fw[i] = 5'd1; fh[i] = 5'd1; fc[i] = 3'd0;
        end
        fx[1] = 8'd10; fy[1] = 7'd20; fw[1] = 5'd4; fh[1] = 5'd2; fc[1] = 3'b101;
        issue(4'b0010, 1'b0);
        @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'(1));
        check("en_latency", 64'(drw_en), 64'(1));
        wait_done(en_cyc);

        // Zero-width request from source 0 is skipped: ack with no drawer enable.
        fw[0] = 5'd0;
        issue(4'b0001, 1'b0);
        @(posedge clk);
        #1;
        check("skip_ack", 64'({drw_en, ack}), 64'({1'b0, 4'b0001}));
        wait_done(en_cyc);
        check("skip_no_en", 64'(en_cyc), 64'(0));

        // Clear and source 2 together: clear first.
        fw[0] = 5'd1;
        fx[2] = 8'd159; fy[2] = 7'd119; fw[2] = 5'd31; fh[2] = 5'd31; fc[2] = 3'd6;
        issue(4'b0100, 1'b1);
        wait_done(en_cyc);

        // Random batches.
        for (int b = 0; b < 40; b++) begin
            rand_fields();
            issue(N'($urandom_range(1, (1 << N) - 1)), ($urandom_range(0, 3) == 0));
            wait_done(en_cyc);
        end
        check("no_spurious_timeout", 64'(timeout_err), 64'(0));

        // Watchdog abort: drawer never finishes.
        hold_done = 1'b1;
        rand_fields();
        fx[3] = 8'd0; fy[3] = 7'd0; fw[3] = 5'd8; fh[3] = 5'd8;
        issue(4'b1000, 1'b0);
        wait_done(en_cyc);
        check("timeout_cycles", 64'(en_cyc), 64'(TO));
        check("timeout_err_set", 64'(timeout_err), 64'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("timeout_err_clr", 64'(timeout_err), 64'(0));

        // Asynchronous reset mid-draw abandons the job.
        fx[1] = 8'd5; fy[1] = 7'd5; fw[1] = 5'd3; fh[1] = 5'd3;
        issue(4'b0010, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_en", 64'(drw_en), 64'(1));
        reset = 1'b1;
        #1;
        check("async_rst_outs", 64'({drw_en, busy, ack, clear_ack}), 64'(0));
        req = '0;
        exp_q.delete();
        rr_m = 0;
        hold_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            fx[i] = 8'(20 * i); fy[i] = 7'(10 * i); fw[i] = 5'(i + 1); fh[i] = 5'(i + 2);
            fc[i] = 3'(i);
        end
        issue(4'b1111, 1'b0);
        wait_done(en_cyc);

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
